wb_ctrl_pipe: RTL and testbench

Parametrised pipelined control chain for the MIPS pipeline. It decodes each instruction once on entry to the execute stage and carries the decoded writeback controls down a configurable number of stages. At every stage it exposes the destination register, the write-enable and a saturating Tnew countdown. From that state it raises the load-use / producer-not-ready stall request for the decode stage and drives the final-stage register-file write controls.

---
 rtl/wb_ctrl_pipe.sv | 182 ++++++++++++++++++
 tb/tb_wb_ctrl_pipe.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ctrl_pipe.sv
// wb_ctrl_pipe: decodes each instruction once as it enters the execute stage
// and carries its writeback controls down STAGES pipeline stages.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-low reset
//   instr_d/valid_d  instruction in decode and its valid flag
//   rs_d/rt_d        source registers read in decode
//   tuse_rs/tuse_rt  cycles until decode needs each operand (3 = unused)
//   flush            kill the instruction entering stage 0
//   stall_req        decode must hold; stage 0 receives a bubble
//   stage_dst/tnew/wr  per-stage destination, Tnew countdown, write flag
//   w_*              final-stage register-file write controls
module wb_ctrl_pipe #(
  parameter int STAGES = 3,
  parameter int TW     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            instr_d,
  input  logic                   valid_d,
  input  logic [4:0]             rs_d,
  input  logic [4:0]             rt_d,
  input  logic [1:0]             tuse_rs,
  input  logic [1:0]             tuse_rt,
  input  logic                   flush,
  output logic                   stall_req,
  output logic [5*STAGES-1:0]    stage_dst,
  output logic [TW*STAGES-1:0]   stage_tnew,
  output logic [STAGES-1:0]      stage_wr,
  output logic                   w_rfwr,
  output logic [4:0]             w_dst,
  output logic [1:0]             w_m2sel,
  output logic [2:0]             w_ldop,
  output logic [31:0]            w_instr
);

  // Common width for comparing Tnew against the 2-bit Tuse.
  localparam int CW = (TW > 2) ? TW : 2;

  typedef struct packed {
    logic [31:0]   instr;
    logic [4:0]    dst;
    logic [TW-1:0] tnew;
    logic          wr;
    logic [1:0]    m2sel;
    logic [2:0]    ldop;
  } ctl_t;

  ctl_t [STAGES-1:0] stg_q;
  ctl_t [STAGES-1:0] stg_d;
  logic [STAGES-1:0] hit;

  function automatic ctl_t bubble_ctl();
    ctl_t c;
    c.instr = 32'd0;
    c.dst   = 5'd0;
    c.tnew  = {TW{1'b0}};
    c.wr    = 1'b0;
    c.m2sel = 2'd0;
    c.ldop  = 3'd5;
    return c;
  endfunction

  function automatic ctl_t decode_ctl(input logic [31:0] ins);
    ctl_t       c;
    logic       writer;
    logic [4:0] dst;
    c       = bubble_ctl();
    c.instr = ins;
    writer  = 1'b0;
    dst     = 5'd0;
    case (ins[31:26])
      6'h00: begin
        case (ins[5:0])
          // shifts, mfhi/mflo, ALU R-type
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
          6'h10, 6'h12,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2a, 6'h2b: begin
            writer = 1'b1;
            dst    = ins[15:11];
            c.tnew = TW'(2'd1);
          end
          6'h09: begin // jalr: link value is ready at entry
            writer  = 1'b1;
            dst     = ins[15:11];
            c.m2sel = 2'd2;
          end
          default: writer = 1'b0;
        endcase
      end
      6'h03: begin // jal
        writer  = 1'b1;
        dst     = 5'd31;
        c.m2sel = 2'd2;
      end
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
        writer = 1'b1;
        dst    = ins[20:16];
        c.tnew = TW'(2'd1);
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        writer  = 1'b1;
        dst     = ins[20:16];
        c.tnew  = TW'(2'd2);
        c.m2sel = 2'd1;
        case (ins[31:26])
          6'h23:   c.ldop = 3'd0;
          6'h20:   c.ldop = 3'd1;
          6'h24:   c.ldop = 3'd2;
          6'h21:   c.ldop = 3'd3;
          6'h25:   c.ldop = 3'd4;
          default: c.ldop = 3'd5;
        endcase
      end
      default: writer = 1'b0;
    endcase
    c.dst = dst;
    // A write to $0 is never flagged, so it can never stall or forward.
    c.wr  = writer && (dst != 5'd0);
    return c;
  endfunction

  // Hazard detection: a stage stalls decode when it will write a register
  // that decode needs before the producer can supply it.
  always_comb begin
    hit = {STAGES{1'b0}};
    for (int i = 0; i < STAGES; i++) begin
      hit[i] = valid_d && stg_q[i].wr &&
               (((tuse_rs != 2'd3) && (stg_q[i].dst == rs_d) &&
                 (CW'(stg_q[i].tnew) > CW'(tuse_rs))) ||
                ((tuse_rt != 2'd3) && (stg_q[i].dst == rt_d) &&
                 (CW'(stg_q[i].tnew) > CW'(tuse_rt))));
    end
    stall_req = |hit;
  end

  // Next-state: stage 0 decodes or bubbles; later stages shift with a
  // saturating Tnew decrement.
  always_comb begin
    stg_d = stg_q;
    if (valid_d && !stall_req && !flush) begin
      stg_d[0] = decode_ctl(instr_d);
    end else begin
      stg_d[0] = bubble_ctl();
    end
    for (int i = 1; i < STAGES; i++) begin
      stg_d[i] = stg_q[i-1];
      stg_d[i].tnew = (stg_q[i-1].tnew == {TW{1'b0}}) ? {TW{1'b0}}
                                                      : stg_q[i-1].tnew - TW'(1'b1);
    end
  end

  // Stage registers; reset discards every in-flight instruction at once.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stg_q[i] <= bubble_ctl();
      end
    end else begin
      stg_q <= stg_d;
    end
  end

  // Flatten stage state onto the output buses.
  always_comb begin
    stage_dst  = {(5*STAGES){1'b0}};
    stage_tnew = {(TW*STAGES){1'b0}};
    stage_wr   = {STAGES{1'b0}};
    for (int i = 0; i < STAGES; i++) begin
      stage_dst[5*i +: 5]   = stg_q[i].dst;
      stage_tnew[TW*i +: TW] = stg_q[i].tnew;
      stage_wr[i]           = stg_q[i].wr;
    end
    w_rfwr  = stg_q[STAGES-1].wr;
    w_dst   = stg_q[STAGES-1].dst;
    w_m2sel = stg_q[STAGES-1].m2sel;
    w_ldop  = stg_q[STAGES-1].ldop;
    w_instr = stg_q[STAGES-1].instr;
  end

endmodule

// File: tb/tb_wb_ctrl_pipe.sv
// Directed testbench for wb_ctrl_pipe: a 3-stage and a 4-stage instance.
module tb_wb_ctrl_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] instr_d;
  logic        valid_d;
  logic [4:0]  rs_d, rt_d;
  logic [1:0]  tuse_rs, tuse_rt;
  logic        flush;
  logic        stall_req;
  logic [14:0] stage_dst;
  logic [5:0]  stage_tnew;
  logic [2:0]  stage_wr;
  logic        w_rfwr;
  logic [4:0]  w_dst;
  logic [1:0]  w_m2sel;
  logic [2:0]  w_ldop;
  logic [31:0] w_instr;

  logic [31:0] instr4;
  logic        valid4;
  logic [4:0]  rs4, rt4;
  logic [1:0]  tus4, tut4;
  logic        flush4;
  logic        stall4;
  logic [19:0] stage_dst4;
  logic [7:0]  stage_tnew4;
  logic [3:0]  stage_wr4;
  logic        w_rfwr4;
  logic [4:0]  w_dst4;
  logic [1:0]  w_m2sel4;
  logic [2:0]  w_ldop4;
  logic [31:0] w_instr4;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] LW8      = 32'h8D280000; // lw   $8,0($9)
  localparam logic [31:0] ADDU10   = 32'h01085021; // addu $10,$8,$8
  localparam logic [31:0] JAL      = 32'h0C000010; // jal
  localparam logic [31:0] ADDU2_31 = 32'h03E01021; // addu $2,$31,$0
  localparam logic [31:0] ADDU0    = 32'h00220021; // addu $0,$1,$2
  localparam logic [31:0] SW0      = 32'hAC000000; // sw   $0,0($0)
  localparam logic [31:0] LH3      = 32'h84830000; // lh   $3,0($4)
  localparam logic [31:0] LB5      = 32'h80C50000; // lb   $5,0($6)

  wb_ctrl_pipe #(.STAGES(3), .TW(2)) dut3 (
    .clk(clk), .reset(reset), .instr_d(instr_d), .valid_d(valid_d),
    .rs_d(rs_d), .rt_d(rt_d), .tuse_rs(tuse_rs), .tuse_rt(tuse_rt),
    .flush(flush), .stall_req(stall_req), .stage_dst(stage_dst),
    .stage_tnew(stage_tnew), .stage_wr(stage_wr), .w_rfwr(w_rfwr),
    .w_dst(w_dst), .w_m2sel(w_m2sel), .w_ldop(w_ldop), .w_instr(w_instr)
  );

  wb_ctrl_pipe #(.STAGES(4), .TW(2)) dut4 (
    .clk(clk), .reset(reset), .instr_d(instr4), .valid_d(valid4),
    .rs_d(rs4), .rt_d(rt4), .tuse_rs(tus4), .tuse_rt(tut4),
    .flush(flush4), .stall_req(stall4), .stage_dst(stage_dst4),
    .stage_tnew(stage_tnew4), .stage_wr(stage_wr4), .w_rfwr(w_rfwr4),
    .w_dst(w_dst4), .w_m2sel(w_m2sel4), .w_ldop(w_ldop4), .w_instr(w_instr4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic v, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [1:0] tus, input logic [1:0] tut,
                       input logic fl);
    instr_d = ins; valid_d = v; rs_d = rs; rt_d = rt;
    tuse_rs = tus; tuse_rt = tut; flush = fl;
    #1;
  endtask

  task automatic idle(input int n);
    drive(32'd0, 1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 1'b0);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    tick();
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b exp 0", stall_req); end
    checks++; if (stage_dst !== 15'd0) begin errors++; $display("FAIL rst_dst got %h exp 0", stage_dst); end
    checks++; if (stage_tnew !== 6'd0) begin errors++; $display("FAIL rst_tnew got %h exp 0", stage_tnew); end
    checks++; if (stage_wr !== 3'd0) begin errors++; $display("FAIL rst_wr got %b exp 000", stage_wr); end
    checks++; if (w_rfwr !== 1'b0 || w_dst !== 5'd0 || w_m2sel !== 2'd0)
      begin errors++; $display("FAIL rst_w got rfwr=%0b dst=%0d m2sel=%0d exp 0/0/0", w_rfwr, w_dst, w_m2sel); end
    checks++; if (w_ldop !== 3'd5) begin errors++; $display("FAIL rst_ldop got %0d exp 5", w_ldop); end
    checks++; if (w_instr !== 32'd0) begin errors++; $display("FAIL rst_instr got %h exp 0", w_instr); end
    checks++; if (w_ldop4 !== 3'd5 || stage_wr4 !== 4'd0)
      begin errors++; $display("FAIL rst4 got ldop=%0d wr=%b exp 5/0000", w_ldop4, stage_wr4); end
  endtask

  task automatic test_load_use();
    drive(LW8, 1'b1, 5'd9, 5'd8, 2'd1, 2'd3, 1'b0);
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL lu_nostall got %0b exp 0", stall_req); end
    tick();
    checks++; if (stage_dst[4:0] !== 5'd8 || stage_tnew[1:0] !== 2'd2 || stage_wr !== 3'b001)
      begin errors++; $display("FAIL lu_s0 got dst=%0d tnew=%0d wr=%b exp 8/2/001", stage_dst[4:0], stage_tnew[1:0], stage_wr); end
    drive(ADDU10, 1'b1, 5'd8, 5'd8, 2'd1, 2'd1, 1'b0);
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL lu_stall got %0b exp 1", stall_req); end
    tick();
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL lu_release got %0b exp 0", stall_req); end
    checks++; if (stage_wr !== 3'b010 || stage_tnew !== 6'b00_01_00)
      begin errors++; $display("FAIL lu_bubble got wr=%b tnew=%b exp 010/000100", stage_wr, stage_tnew); end
    tick();
    checks++; if (stage_dst !== {5'd8, 5'd0, 5'd10})
      begin errors++; $display("FAIL lu_addu got %h exp %h", stage_dst, {5'd8, 5'd0, 5'd10}); end
    checks++; if (w_m2sel !== 2'd1 || w_ldop !== 3'd0 || w_dst !== 5'd8 || w_rfwr !== 1'b1)
      begin errors++; $display("FAIL lu_w got m2sel=%0d ldop=%0d dst=%0d rfwr=%0b exp 1/0/8/1", w_m2sel, w_ldop, w_dst, w_rfwr); end
    checks++; if (w_instr !== LW8 || stage_tnew !== 6'b00_00_01)
      begin errors++; $display("FAIL lu_winstr got %h tnew=%b exp %h/000001", w_instr, stage_tnew, LW8); end
    idle(3);
  endtask

  task automatic test_load_tuse0();
    drive(LW8, 1'b1, 5'd9, 5'd8, 2'd1, 2'd3, 1'b0);
    tick();
    drive(ADDU10, 1'b1, 5'd8, 5'd0, 2'd0, 2'd3, 1'b0);
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL t0_stall1 got %0b exp 1", stall_req); end
    tick();
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL t0_stall2 got %0b exp 1", stall_req); end
    tick();
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL t0_release got %0b exp 0", stall_req); end
    tick();
    checks++; if (stage_dst[4:0] !== 5'd10 || stage_wr !== 3'b001)
      begin errors++; $display("FAIL t0_enter got dst=%0d wr=%b exp 10/001", stage_dst[4:0], stage_wr); end
    idle(3);
  endtask

  task automatic test_jal();
    drive(JAL, 1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 1'b0);
    tick();
    checks++; if (stage_dst[4:0] !== 5'd31 || stage_tnew[1:0] !== 2'd0 || stage_wr[0] !== 1'b1)
      begin errors++; $display("FAIL jal_s0 got dst=%0d tnew=%0d wr=%0b exp 31/0/1", stage_dst[4:0], stage_tnew[1:0], stage_wr[0]); end
    drive(ADDU2_31, 1'b1, 5'd31, 5'd0, 2'd0, 2'd3, 1'b0);
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL jal_nostall got %0b exp 0", stall_req); end
    tick();
    idle(1);
    checks++; if (w_m2sel !== 2'd2 || w_rfwr !== 1'b1 || w_dst !== 5'd31 || w_ldop !== 3'd5)
      begin errors++; $display("FAIL jal_w got m2sel=%0d rfwr=%0b dst=%0d ldop=%0d exp 2/1/31/5", w_m2sel, w_rfwr, w_dst, w_ldop); end
    idle(3);
  endtask

  task automatic test_write_zero();
    drive(ADDU0, 1'b1, 5'd1, 5'd2, 2'd1, 2'd1, 1'b0);
    tick();
    checks++; if (stage_wr !== 3'b000) begin errors++; $display("FAIL z_wr0 got %b exp 000", stage_wr); end
    drive(SW0, 1'b1, 5'd0, 5'd0, 2'd1, 2'd2, 1'b0);
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL z_stall got %0b exp 0", stall_req); end
    tick();
    checks++; if (stage_wr !== 3'b000 || stage_dst !== 15'd0)
      begin errors++; $display("FAIL z_wr1 got wr=%b dst=%h exp 000/0", stage_wr, stage_dst); end
    idle(1);
    checks++; if (w_instr !== ADDU0 || w_rfwr !== 1'b0 || stage_wr !== 3'b000)
      begin errors++; $display("FAIL z_w got instr=%h rfwr=%0b wr=%b exp %h/0/000", w_instr, w_rfwr, stage_wr, ADDU0); end
    idle(3);
  endtask

  task automatic test_flush();
    drive(LH3, 1'b1, 5'd4, 5'd3, 2'd1, 2'd3, 1'b1);
    tick();
    checks++; if (stage_wr !== 3'b000 || stage_dst !== 15'd0 || stage_tnew !== 6'd0)
      begin errors++; $display("FAIL fl_s0 got wr=%b dst=%h tnew=%h exp 0/0/0", stage_wr, stage_dst, stage_tnew); end
    idle(2);
    checks++; if (w_instr !== 32'd0 || w_rfwr !== 1'b0)
      begin errors++; $display("FAIL fl_w got instr=%h rfwr=%0b exp 0/0", w_instr, w_rfwr); end
    drive(LH3, 1'b1, 5'd4, 5'd3, 2'd1, 2'd3, 1'b0);
    tick();
    checks++; if (stage_tnew[1:0] !== 2'd2 || stage_dst[4:0] !== 5'd3)
      begin errors++; $display("FAIL fl_lh got tnew=%0d dst=%0d exp 2/3", stage_tnew[1:0], stage_dst[4:0]); end
    idle(2);
    checks++; if (w_ldop !== 3'd3 || w_dst !== 5'd3 || w_m2sel !== 2'd1)
      begin errors++; $display("FAIL fl_lhw got ldop=%0d dst=%0d m2sel=%0d exp 3/3/1", w_ldop, w_dst, w_m2sel); end
    idle(3);
  endtask

  task automatic test_flush_stall();
    drive(LW8, 1'b1, 5'd9, 5'd8, 2'd1, 2'd3, 1'b0);
    tick();
    drive(ADDU10, 1'b1, 5'd8, 5'd8, 2'd1, 2'd1, 1'b1);
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL fs_stall got %0b exp 1", stall_req); end
    tick();
    checks++; if (stage_wr !== 3'b010) begin errors++; $display("FAIL fs_bubble got %b exp 010", stage_wr); end
    drive(ADDU10, 1'b1, 5'd8, 5'd8, 2'd1, 2'd1, 1'b0);
    tick();
    checks++; if (stage_dst[4:0] !== 5'd10) begin errors++; $display("FAIL fs_enter got %0d exp 10", stage_dst[4:0]); end
    idle(3);
  endtask

  task automatic test_midstream_reset();
    drive(LW8, 1'b1, 5'd9, 5'd8, 2'd1, 2'd3, 1'b0);
    tick();
    drive(JAL, 1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 1'b0);
    tick();
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    checks++; if (stage_wr !== 3'b000 || stage_dst !== 15'd0)
      begin errors++; $display("FAIL mr_clear got wr=%b dst=%h exp 000/0", stage_wr, stage_dst); end
    checks++; if (w_rfwr !== 1'b0 || w_ldop !== 3'd5 || w_instr !== 32'd0)
      begin errors++; $display("FAIL mr_w got rfwr=%0b ldop=%0d instr=%h exp 0/5/0", w_rfwr, w_ldop, w_instr); end
    idle(1);
    checks++; if (w_instr !== 32'd0) begin errors++; $display("FAIL mr_nodrain got %h exp 0", w_instr); end
    idle(2);
  endtask

  task automatic test_stages4();
    instr4 = LB5; valid4 = 1'b1; rs4 = 5'd6; rt4 = 5'd5; tus4 = 2'd1; tut4 = 2'd3; flush4 = 1'b0;
    #1;
    checks++; if (stall4 !== 1'b0) begin errors++; $display("FAIL s4_stall got %0b exp 0", stall4); end
    tick();
    checks++; if (stage_tnew4 !== 8'h02) begin errors++; $display("FAIL s4_t1 got %h exp 02", stage_tnew4); end
    tick(); tick(); tick();
    checks++; if (stage_tnew4 !== 8'h06 || stage_wr4 !== 4'hF)
      begin errors++; $display("FAIL s4_tnew got %h wr=%b exp 06/1111", stage_tnew4, stage_wr4); end
    checks++; if (w_ldop4 !== 3'd1 || w_dst4 !== 5'd5 || w_rfwr4 !== 1'b1 || w_m2sel4 !== 2'd1)
      begin errors++; $display("FAIL s4_w got ldop=%0d dst=%0d rfwr=%0b m2sel=%0d exp 1/5/1/1", w_ldop4, w_dst4, w_rfwr4, w_m2sel4); end
    valid4 = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b0;
    instr_d = 32'd0; valid_d = 1'b0; rs_d = 5'd0; rt_d = 5'd0;
    tuse_rs = 2'd3; tuse_rt = 2'd3; flush = 1'b0;
    instr4 = 32'd0; valid4 = 1'b0; rs4 = 5'd0; rt4 = 5'd0;
    tus4 = 2'd3; tut4 = 2'd3; flush4 = 1'b0;
    test_reset();
    test_load_use();
    test_load_tuse0();
    test_jal();
    test_write_zero();
    test_flush();
    test_flush_stall();
    test_midstream_reset();
    test_stages4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
